// File: rtl/ahb2apb_pkg.sv
// rtl/ahb2apb_pkg.sv - shared encodings and FSM state type for the AHB-Lite to APB3 bridge
// Contents: htrans codes, hresp codes, bridge state enum.
package ahb2apb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// rtl/ahb2apb_bridge_if.sv - AHB-Lite slave side and APB3 master side signal bundle of the bridge
// Modports:
//   slave  - bridge view: AHB inputs/responses out, APB requests out/completions in
//   master - environment view (AHB master + APB slaves), directions mirrored
interface ahb2apb_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
) ();

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready_in;
  logic              hready_out;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  logic [ADDR_W-1:0]  paddr;
  logic [NUM_SLV-1:0] psel;
  logic               penable;
  logic               pwrite;
  logic [DATA_W-1:0]  pwdata;
  logic [DATA_W-1:0]  prdata;
  logic               pready;
  logic               pslverr;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    output hready_out, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    input  hready_out, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/ahb2apb_bridge_apb_slave_decoder.sv
// rtl/ahb2apb_bridge_apb_slave_decoder.sv - maps the 4-bit slave index to a one-hot psel vector
// Ports:
//   idx   in  4        slave index field taken from haddr
//   sel   out NUM_SLV  one-hot select, all zero when idx is out of range
//   valid out 1        idx addresses an existing slave
module apb_slave_decoder #(
  parameter int NUM_SLV = 4
) (
  input  logic [3:0]         idx,
  output logic [NUM_SLV-1:0] sel,
  output logic               valid
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (32'(idx) == i) sel[i] = 1'b1;
    end
  end

  assign valid = (32'(idx) < NUM_SLV);

endmodule

// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - AHB-Lite slave to APB3 master bridge, one APB transfer per AHB beat
// Ports:
//   hclk   in  1  bus clock, all state on posedge
//   hreset in  1  asynchronous active-high reset
//   bus    ahb2apb_if.slave  AHB-Lite request/response and APB3 master signals
module ahb2apb_bridge
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12
) (
  input  logic     hclk,
  input  logic     hreset,
  ahb2apb_if.slave bus
);

  state_t state, state_nx;

  logic [ADDR_W-1:0]  paddr_q;
  logic               pwrite_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [DATA_W-1:0]  hrdata_q;
  logic [NUM_SLV-1:0] sel_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;

  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_valid;
  logic               accept;
  logic               done_ok;
  logic               take;
  logic               hready_c;
  logic               hresp_c;

  // hsize is irrelevant (word access only) and only htrans[1] decides a real transfer.
  logic unused_bits;
  assign unused_bits = ^{bus.hsize, bus.htrans[0]};

  apb_slave_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
    .idx   (bus.haddr[SEL_LSB+3:SEL_LSB]),
    .sel   (dec_sel),
    .valid (dec_valid)
  );

  assign accept  = bus.hsel & bus.hready_in & bus.htrans[1];
  assign done_ok = (state == ACCESS) & bus.pready & ~bus.pslverr;
  // A new address phase can only land in a cycle where we drive hready_out high.
  assign take    = accept & ((state == IDLE) | (state == ERR2) | done_ok);

  always_comb begin
    state_nx = state;
    hready_c = 1'b1;
    hresp_c  = RESP_OKAY;
    case (state)
      IDLE: begin
        if (take) state_nx = dec_valid ? LATCH : ERR1;
      end
      LATCH: begin
        hready_c = 1'b0;
        state_nx = SETUP;
      end
      SETUP: begin
        hready_c = 1'b0;
        state_nx = ACCESS;
      end
      ACCESS: begin
        if (!bus.pready) begin
          hready_c = 1'b0;
        end else if (bus.pslverr) begin
          // First cycle of the two-cycle ERROR response.
          hready_c = 1'b0;
          hresp_c  = RESP_ERROR;
          state_nx = ERR2;
        end else if (take) begin
          state_nx = dec_valid ? LATCH : ERR1;
        end else begin
          state_nx = IDLE;
        end
      end
      ERR1: begin
        hready_c = 1'b0;
        hresp_c  = RESP_ERROR;
        state_nx = ERR2;
      end
      ERR2: begin
        hresp_c  = RESP_ERROR;
        if (take) state_nx = dec_valid ? LATCH : ERR1;
        else      state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      sel_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        paddr_q  <= bus.haddr;
        pwrite_q <= bus.hwrite;
        sel_q    <= dec_sel;
      end
      // hwdata belongs to the data phase, which is the LATCH cycle.
      if (state == LATCH && pwrite_q) pwdata_q <= bus.hwdata;
      if (done_ok && !pwrite_q) hrdata_q <= bus.prdata;

      case (state_nx)
        SETUP:   psel_q <= sel_q;
        ACCESS:  psel_q <= psel_q;
        // Back-to-back: select moves straight to the new slave without dropping.
        LATCH:   psel_q <= (state == ACCESS) ? dec_sel : '0;
        default: psel_q <= '0;
      endcase
      penable_q <= (state_nx == ACCESS);
    end
  end

  assign bus.hready_out = hready_c;
  assign bus.hresp      = hresp_c;
  // Read data bypasses the register in the completing cycle, register holds it afterwards.
  assign bus.hrdata     = (done_ok && !pwrite_q) ? bus.prdata : hrdata_q;
  assign bus.paddr      = paddr_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.pwdata     = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb/tb_ahb2apb_bridge.sv - scoreboard bench for ahb2apb_bridge
module tb_ahb2apb_bridge;
  import ahb2apb_pkg::*;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  ahb2apb_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  ahb2apb_bridge #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(12)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  assign bus.hready_in = bus.hready_out;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] rdata;
    int          waits;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        wr;
    logic [31:0] wdata;
    int          en_cycles;
  } apb_exp_t;

  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];
  ahb_exp_t ae;
  apb_exp_t pe;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // APB slave model: pready rises after wait_req ACCESS cycles.
  int wait_req = 0;
  int acc_cnt = 0;
  logic [31:0] prdata_v = 32'h0;
  logic pslverr_v = 1'b0;
  assign bus.prdata  = prdata_v;
  assign bus.pslverr = pslverr_v;

  always @(posedge hclk) begin
    #1;
    if ((|bus.psel) && bus.penable) acc_cnt++;
    else acc_cnt = 0;
    bus.pready = (acc_cnt > wait_req);
  end

  // Monitor: pops expected APB and AHB completions and compares.
  logic dphase = 1'b0;
  int waits = 0;
  logic prev_hresp = 1'b0;
  int en_cnt = 0;
  int viol = 0;

  always @(negedge hclk) begin
    if (hreset) begin
      dphase = 1'b0;
      en_cnt = 0;
    end else begin
      if (bus.penable && !(|bus.psel)) viol++;
      if ((|bus.psel) && bus.penable) begin
        en_cnt++;
        if (bus.pready) begin
          if (apb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL apb_unexpected: paddr 0x%0h psel 0x%0h", bus.paddr, bus.psel);
          end else begin
            pe = apb_q.pop_front();
            check("paddr", bus.paddr, pe.addr);
            check("psel", 32'(bus.psel), 32'(pe.sel));
            check("pwrite", 32'(bus.pwrite), 32'(pe.wr));
            if (pe.wr) check("pwdata", bus.pwdata, pe.wdata);
            check("penable_cycles", 32'(en_cnt), 32'(pe.en_cycles));
          end
          en_cnt = 0;
        end
      end
      if (dphase) begin
        if (bus.hready_out) begin
          if (ahb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ahb_unexpected: hresp %0d", bus.hresp);
          end else begin
            ae = ahb_q.pop_front();
            check("hresp", 32'(bus.hresp), 32'(ae.err));
            check("wait_cycles", 32'(waits), 32'(ae.waits));
            if (ae.err) check("hresp_first_err_cycle", 32'(prev_hresp), 32'(1));
            if (ae.rd && !ae.err) check("hrdata", bus.hrdata, ae.rdata);
          end
          dphase = 1'b0;
        end else begin
          waits++;
          prev_hresp = bus.hresp;
        end
      end
      if (bus.hsel && bus.hready_in && bus.htrans[1]) begin
        dphase = 1'b1;
        waits = 0;
        prev_hresp = 1'b0;
      end
    end
  end

  task automatic push_ahb(input logic err, input logic rd, input logic [31:0] rdata, input int w);
    ahb_exp_t e;
    e.err = err; e.rd = rd; e.rdata = rdata; e.waits = w;
    ahb_q.push_back(e);
  endtask

  task automatic push_apb(input logic [31:0] a, input logic [3:0] s, input logic wr,
                          input logic [31:0] wd, input int en);
    apb_exp_t e;
    e.addr = a; e.sel = s; e.wr = wr; e.wdata = wd; e.en_cycles = en;
    apb_q.push_back(e);
  endtask

  // Present an address phase and return just after the posedge that accepts it.
  task automatic addr_phase(input logic [31:0] a, input logic w);
    int n;
    bus.hsel   = 1'b1;
    bus.haddr  = a;
    bus.htrans = TRANS_NONSEQ;
    bus.hwrite = w;
    n = 0;
    @(negedge hclk);
    while (!bus.hready_out && n < 50) begin
      n++;
      @(negedge hclk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL addr_timeout: hready_out stuck at %0d", bus.hready_out);
    end
    @(posedge hclk);
    #1;
    bus.hsel   = 1'b0;
    bus.htrans = TRANS_IDLE;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ahb_q.size() != 0 || dphase) && n < 100) begin
      n++;
      @(negedge hclk);
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: %0d responses outstanding", ahb_q.size());
    end
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hsel   = 1'b0;
    bus.haddr  = 32'h0;
    bus.htrans = TRANS_IDLE;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'b010;
    bus.hwdata = 32'h0;
    hreset     = 1'b1;

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst_hready_out", 32'(bus.hready_out), 32'(1));
    check("rst_hresp", 32'(bus.hresp), 32'(0));
    check("rst_psel", 32'(bus.psel), 32'(0));
    check("rst_penable", 32'(bus.penable), 32'(0));
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_hrdata", bus.hrdata, 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(posedge hclk);
    #1;

    // Zero-wait write to slave 1.
    push_ahb(1'b0, 1'b0, 32'h0, 2);
    push_apb(32'h0000_1004, 4'b0010, 1'b1, 32'hDEAD_BEEF, 1);
    addr_phase(32'h0000_1004, 1'b1);
    bus.hwdata = 32'hDEAD_BEEF;
    wait_idle();

    // Read from slave 2 with two wait states.
    wait_req  = 2;
    prdata_v  = 32'h1234_5678;
    push_ahb(1'b0, 1'b1, 32'h1234_5678, 4);
    push_apb(32'h0000_2000, 4'b0100, 1'b0, 32'h0, 3);
    addr_phase(32'h0000_2000, 1'b0);
    wait_idle();
    wait_req  = 0;

    // Slave error on a read: read data must not be captured.
    pslverr_v = 1'b1;
    prdata_v  = 32'hFFFF_0000;
    push_ahb(1'b1, 1'b1, 32'h0, 3);
    push_apb(32'h0000_0010, 4'b0001, 1'b0, 32'h0, 1);
    addr_phase(32'h0000_0010, 1'b0);
    wait_idle();
    pslverr_v = 1'b0;
    check("hrdata_hold_after_slverr", bus.hrdata, 32'h1234_5678);

    // Decode error (index 5), then a read accepted during the second error cycle.
    prdata_v = 32'h0BAD_F00D;
    push_ahb(1'b1, 1'b1, 32'h0, 1);
    push_ahb(1'b0, 1'b1, 32'h0BAD_F00D, 2);
    push_apb(32'h0000_1000, 4'b0010, 1'b0, 32'h0, 1);
    addr_phase(32'h0000_5000, 1'b0);
    addr_phase(32'h0000_1000, 1'b0);
    wait_idle();

    // Back-to-back write then read accepted in the completing cycle.
    prdata_v = 32'hA5A5_5A5A;
    push_ahb(1'b0, 1'b0, 32'h0, 2);
    push_ahb(1'b0, 1'b1, 32'hA5A5_5A5A, 2);
    push_apb(32'h0000_0000, 4'b0001, 1'b1, 32'hCAFE_F00D, 1);
    push_apb(32'h0000_3008, 4'b1000, 1'b0, 32'h0, 1);
    addr_phase(32'h0000_0000, 1'b1);
    bus.hwdata = 32'hCAFE_F00D;
    addr_phase(32'h0000_3008, 1'b0);
    check("b2b_latch_hready", 32'(bus.hready_out), 32'(0));
    check("b2b_latch_psel", 32'(bus.psel), 32'(4'b1000));
    @(posedge hclk);
    #1;
    check("b2b_setup_psel", 32'(bus.psel), 32'(4'b1000));
    check("b2b_setup_penable", 32'(bus.penable), 32'(0));
    check("b2b_setup_pwrite", 32'(bus.pwrite), 32'(0));
    check("b2b_setup_paddr", bus.paddr, 32'h0000_3008);
    wait_idle();

    // Reset in the middle of a waiting ACCESS.
    wait_req = 3;
    addr_phase(32'h0000_1000, 1'b1);
    bus.hwdata = 32'h5555_AAAA;
    @(posedge hclk);
    #1;
    @(posedge hclk);
    #1;
    check("mid_access_penable", 32'(bus.penable), 32'(1));
    hreset = 1'b1;
    #1;
    check("mid_rst_psel", 32'(bus.psel), 32'(0));
    check("mid_rst_penable", 32'(bus.penable), 32'(0));
    check("mid_rst_hready_out", 32'(bus.hready_out), 32'(1));
    check("mid_rst_paddr", bus.paddr, 32'h0);
    check("mid_rst_pwdata", bus.pwdata, 32'h0);
    @(posedge hclk);
    #1;
    hreset   = 1'b0;
    wait_req = 0;
    repeat (2) @(posedge hclk);
    #1;

    check("penable_without_psel", 32'(viol), 32'(0));
    check("ahb_queue_empty", 32'(ahb_q.size()), 32'(0));
    check("apb_queue_empty", 32'(apb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
